// File: rtl/pulse_period_meter_pkg.sv
//------------------------------------------------------------------------------
// pulse_period_meter_pkg: state encoding and the saturation helper that the
// period counter family shares.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pulse_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        OVF     = 2'd2
    } state_t;

    // All-ones value of a width-bit unsigned counter (valid for widths up to 31).
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_period_meter_rise_detect.sv
//------------------------------------------------------------------------------
// rise_detect: single-cycle rising-edge detector for an already synchronous
// input.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= d;
        end
    end

    assign rise = d & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pulse_period_meter.sv
//------------------------------------------------------------------------------
// pulse_period_meter: measures the spacing between rising edges of a pulse
// stream and reports lock against an expected period, plus a saturation flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int MAX_SIZE   = 8,
    parameter int P          = 10,
    parameter int LOCK_COUNT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pulse_in,
    output logic [MAX_SIZE-1:0] period_out,
    output logic                period_valid,
    output logic                locked,
    output logic                overflow
);

    localparam int                  MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [MAX_SIZE-1:0] CNT_MAX = MAX_SIZE'(cnt_max(MAX_SIZE));
    localparam logic [MAX_SIZE-1:0] CNT_ONE = MAX_SIZE'(1);
    localparam logic [MAX_SIZE-1:0] P_CNT   = MAX_SIZE'(P);
    localparam logic [MATCH_W-1:0]  LOCK_M  = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0]  M_ONE   = MATCH_W'(1);

    state_t              r_state;
    logic [MAX_SIZE-1:0] r_cnt;
    logic [MATCH_W-1:0]  r_match;
    logic [MAX_SIZE-1:0] r_period_out;
    logic                r_period_valid;
    logic                r_locked;
    logic                r_overflow;

    logic                w_rise;
    logic [MATCH_W-1:0]  w_match_next;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .d     (pulse_in),
        .rise  (w_rise)
    );

    // Matching run length saturates at LOCK_COUNT; any miss restarts it.
    always_comb begin
        w_match_next = '0;
        if (r_cnt == P_CNT) begin
            w_match_next = (r_match == LOCK_M) ? r_match : (r_match + M_ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_match        <= '0;
            r_period_out   <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge on the saturating cycle still yields a valid period.
                    if (w_rise) begin
                        r_period_out   <= r_cnt;
                        r_period_valid <= 1'b1;
                        r_cnt          <= CNT_ONE;
                        r_match        <= w_match_next;
                        r_locked       <= (w_match_next == LOCK_M);
                    end else if (r_cnt < CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_overflow <= 1'b1;
                        r_locked   <= 1'b0;
                        r_match    <= '0;
                        r_state    <= OVF;
                    end
                end
                OVF: begin
                    // The interval that spanned the overflow is discarded.
                    if (w_rise) begin
                        r_overflow <= 1'b0;
                        r_cnt      <= CNT_ONE;
                        r_state    <= MEASURE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign period_out   = r_period_out;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire
